// File: rtl/ps2_rx_if.sv
// Read port between the PS/2 receiver and the memory block's PS2 register.
interface ps2_rx_if;
    localparam int unsigned WORD_W = 16;

    logic              ren;
    logic [WORD_W-1:0] data_out;
    logic              not_empty;

    modport master (output ren, input data_out, input not_empty);
    modport slave  (input ren, output data_out, output not_empty);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin conditioning, frame deserializer and a
// scan-code FIFO exposed as a 16-bit status/data word with pop-on-read.
module ps2_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.slave  bus
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            push_c, ferr_set_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             ovf, ferr;
    logic             empty_c, full_c, pop_c, wr_c, ovf_set_c;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: follow the synchronized clock only after FILTER_LEN stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Frame sequencing: start, 8 data bits LSB first, odd parity, stop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        to_cnt_d   = '0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall && !dat_s2) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (dat_s2 && ((^shift_q) ^ par_q)) begin
                        push_c = 1'b1;
                    end else begin
                        ferr_set_c = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled partial frame is dropped silently.
        if (state_q != S_IDLE && !fall) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_d == TO_W'(TIMEOUT)) begin
                state_d  = S_IDLE;
                shift_d  = '0;
                to_cnt_d = '0;
            end
        end
    end

    assign empty_c   = (wptr == rptr);
    assign full_c    = (wptr[PTR_W-1] != rptr[PTR_W-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_c     = bus.ren & ~empty_c;
    assign wr_c      = push_c & (~full_c | pop_c);
    assign ovf_set_c = push_c & full_c & ~pop_c;

    // Pointers and sticky flags; a flag set beats a read clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (wr_c) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (ovf_set_c) begin
                ovf <= 1'b1;
            end else if (bus.ren) begin
                ovf <= 1'b0;
            end
            if (ferr_set_c) begin
                ferr <= 1'b1;
            end else if (bus.ren) begin
                ferr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wptr[AW-1:0]] <= shift_q;
        end
    end

    assign bus.data_out  = {~empty_c, ovf, ferr, 5'b0, empty_c ? 8'h00 : mem[rptr[AW-1:0]]};
    assign bus.not_empty = ~empty_c;

endmodule
